// File: rtl/rx_block_packer.sv
// Packs received I2C bytes into BLOCK_BYTES-wide blocks for the Triple-DES core.
// The block is double-buffered: an assembly register feeds an output register
// that uses a valid/ready handshake. When the macro RXPK_ZERO_PAD_EN is defined,
// a partial block at frame stop is zero-padded and then delivered.
module rx_block_packer #(
  parameter int unsigned BLOCK_BYTES = 8,
  parameter bit          MSB_FIRST   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     byte_strobe,
  input  logic                     frame_start,
  input  logic                     frame_stop,
  input  logic                     block_ready,
  input  logic                     err_clr,
  output logic [8*BLOCK_BYTES-1:0] block_out,
  output logic                     block_valid,
  output logic                     rx_full,
  output logic [3:0]               byte_count,
  output logic                     overflow,
  output logic                     partial_err
);

  localparam int unsigned W    = 8 * BLOCK_BYTES;
  localparam logic [3:0]  LAST = 4'(BLOCK_BYTES - 1);

  typedef enum logic [1:0] {EMPTY, FILL, FULL} state_t;

  state_t         state, state_n;
  logic [W-1:0]   asm_q, asm_n;
  logic [W-1:0]   out_n;
  logic [3:0]     cnt_n;
  logic           valid_n, ovf_n, perr_n;
  logic           drain, complete;

  // Bit position of the low bit of byte slot i within the block.
  function automatic int unsigned slot_lsb(input int unsigned i);
    return MSB_FIRST ? (W - 8 - 8 * i) : (8 * i);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      asm_q       <= '0;
      block_out   <= '0;
      block_valid <= 1'b0;
      rx_full     <= 1'b0;
      byte_count  <= '0;
      overflow    <= 1'b0;
      partial_err <= 1'b0;
    end else begin
      state       <= state_n;
      asm_q       <= asm_n;
      block_out   <= out_n;
      block_valid <= valid_n;
      rx_full     <= (state_n == FULL);
      byte_count  <= cnt_n;
      overflow    <= ovf_n;
      partial_err <= perr_n;
    end
  end

  // Next-state logic. The order of evaluation is: frame_start, then the byte
  // write, then frame_stop, and finally block completion.
  always_comb begin
    state_n  = state;
    asm_n    = asm_q;
    out_n    = block_out;
    valid_n  = block_valid;
    cnt_n    = byte_count;
    ovf_n    = overflow & ~err_clr;
    perr_n   = partial_err & ~err_clr;
    complete = 1'b0;
    drain    = block_valid & block_ready;

    if (drain) valid_n = 1'b0;

    if (state == FULL) begin
      if (byte_strobe) ovf_n = 1'b1;
      if (drain) begin
        out_n   = asm_q;
        valid_n = 1'b1;
        asm_n   = '0;
        state_n = EMPTY;
      end
    end else begin
      if (frame_start) begin
        asm_n = '0;
        cnt_n = '0;
      end
      if (byte_strobe) begin
        for (int unsigned i = 0; i < BLOCK_BYTES; i++) begin
          if (cnt_n == 4'(i)) asm_n[slot_lsb(i) +: 8] = rx_data;
        end
        if (cnt_n == LAST) complete = 1'b1;
        else               cnt_n    = cnt_n + 4'd1;
      end
      if (frame_stop && !complete && (cnt_n != 4'd0)) begin
        perr_n = 1'b1;
`ifdef RXPK_ZERO_PAD_EN
        // The unfilled slots are already zero because the assembly register
        // is cleared at every block boundary.
        complete = 1'b1;
`else
        asm_n = '0;
        cnt_n = '0;
`endif
      end
      if (complete) begin
        cnt_n = '0;
        if (!block_valid || drain) begin
          out_n   = asm_n;
          valid_n = 1'b1;
          asm_n   = '0;
          state_n = EMPTY;
        end else begin
          state_n = FULL;
        end
      end else begin
        state_n = (cnt_n == 4'd0) ? EMPTY : FILL;
      end
    end
  end

endmodule

// File: tb/tb_rx_block_packer.sv
// Directed self-checking bench for rx_block_packer. It instantiates two DUTs that
// share one input stream: one built with MSB-first packing and one with LSB-first.
module tb_rx_block_packer;

  logic        clk = 1'b0;
  logic        rst, byte_strobe, frame_start, frame_stop, block_ready, err_clr;
  logic [7:0]  rx_data;
  logic [63:0] block_out, block_out_l;
  logic        block_valid, rx_full, overflow, partial_err;
  logic        block_valid_l, rx_full_l, overflow_l, partial_err_l;
  logic [3:0]  byte_count, byte_count_l;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rx_block_packer #(.BLOCK_BYTES(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .rx_data(rx_data), .byte_strobe(byte_strobe),
    .frame_start(frame_start), .frame_stop(frame_stop), .block_ready(block_ready),
    .err_clr(err_clr), .block_out(block_out), .block_valid(block_valid),
    .rx_full(rx_full), .byte_count(byte_count), .overflow(overflow),
    .partial_err(partial_err)
  );

  rx_block_packer #(.BLOCK_BYTES(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .rx_data(rx_data), .byte_strobe(byte_strobe),
    .frame_start(frame_start), .frame_stop(frame_stop), .block_ready(block_ready),
    .err_clr(err_clr), .block_out(block_out_l), .block_valid(block_valid_l),
    .rx_full(rx_full_l), .byte_count(byte_count_l), .overflow(overflow_l),
    .partial_err(partial_err_l)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock edge, then sample just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data     = b;
    byte_strobe = 1'b1;
    tick();
    byte_strobe = 1'b0;
  endtask

  initial begin
    rst = 1'b1; byte_strobe = 1'b0; frame_start = 1'b0; frame_stop = 1'b0;
    block_ready = 1'b0; err_clr = 1'b0; rx_data = 8'h00;
    tick(); tick();
    chk("rst_out",   block_out, 64'h0);
    chk("rst_valid", 64'(block_valid), 64'h0);
    chk("rst_full",  64'(rx_full), 64'h0);
    chk("rst_cnt",   64'(byte_count), 64'h0);
    chk("rst_ovf",   64'(overflow), 64'h0);
    chk("rst_perr",  64'(partial_err), 64'h0);
    chk("rst_l_flags", 64'({block_valid_l, rx_full_l, byte_count_l, overflow_l, partial_err_l}), 64'h0);
    rst = 1'b0;

    // Basic 8-byte block with both packing orders; block_ready is held high.
    block_ready = 1'b1;
    for (int i = 1; i <= 7; i++) send(8'(i));
    chk("t1_cnt7",   64'(byte_count), 64'd7);
    chk("t1_nvalid", 64'(block_valid), 64'h0);
    send(8'h08);
    chk("t1_valid",  64'(block_valid), 64'h1);
    chk("t1_out",    block_out, 64'h0102030405060708);
    chk("t1_cnt0",   64'(byte_count), 64'h0);
    chk("t2_out_l",  block_out_l, 64'h0807060504030201);
    chk("t2_valid_l", 64'(block_valid_l), 64'h1);
    tick();
    chk("t1_drained", 64'(block_valid), 64'h0);

    // Backpressure: hold block_ready low while 16 bytes arrive, then add one extra byte.
    block_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i));
    chk("t3_valid",  64'(block_valid), 64'h1);
    chk("t3_out1",   block_out, 64'h1011121314151617);
    chk("t3_full",   64'(rx_full), 64'h1);
    chk("t3_cnt",    64'(byte_count), 64'h0);
    chk("t3_noovf",  64'(overflow), 64'h0);
    send(8'h20);
    chk("t3_ovf",    64'(overflow), 64'h1);
    chk("t3_hold",   block_out, 64'h1011121314151617);
    block_ready = 1'b1;
    tick();
    chk("t3_out2",   block_out, 64'h18191A1B1C1D1E1F);
    chk("t3_valid2", 64'(block_valid), 64'h1);
    chk("t3_nfull",  64'(rx_full), 64'h0);
    tick();
    chk("t3_drain2", 64'(block_valid), 64'h0);
    chk("t3_ovf_sticky", 64'(overflow), 64'h1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3_ovf_clr", 64'(overflow), 64'h0);

    // Partial block terminated by frame_stop.
    send(8'hAA); send(8'hBB); send(8'hCC);
    chk("t4_cnt3", 64'(byte_count), 64'd3);
    frame_stop = 1'b1;
    tick();
    frame_stop = 1'b0;
    chk("t4_perr", 64'(partial_err), 64'h1);
    chk("t4_cnt",  64'(byte_count), 64'h0);
`ifdef RXPK_ZERO_PAD_EN
    chk("t4_valid", 64'(block_valid), 64'h1);
    chk("t4_out",   block_out, 64'hAABBCC0000000000);
`else
    chk("t4_valid", 64'(block_valid), 64'h0);
`endif
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t4_perr_clr", 64'(partial_err), 64'h0);

    // frame_start arrives in the same cycle as byte 0x55, after a 5-byte partial block.
    for (int i = 1; i <= 5; i++) send(8'(i));
    chk("t5_cnt5", 64'(byte_count), 64'd5);
    frame_start = 1'b1;
    send(8'h55);
    frame_start = 1'b0;
    chk("t5_cnt1", 64'(byte_count), 64'd1);
    for (int i = 0; i < 7; i++) send(8'(8'h56 + i));
    chk("t5_valid", 64'(block_valid), 64'h1);
    chk("t5_out",   block_out, 64'h55565758595A5B5C);
    chk("t5_out_l", block_out_l, 64'h5C5B5A5958575655);
    tick();

    // Reset applied in the middle of a block while an output block is pending.
    block_ready = 1'b0;
    for (int i = 0; i < 12; i++) send(8'(8'h60 + i));
    chk("t6_cnt4",  64'(byte_count), 64'd4);
    chk("t6_valid", 64'(block_valid), 64'h1);
    send(8'h70); send(8'h71); send(8'h72); send(8'h73);
    send(8'h74);
    chk("t6_ovf", 64'(overflow), 64'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_out",   block_out, 64'h0);
    chk("t6_rvalid", 64'(block_valid), 64'h0);
    chk("t6_full",  64'(rx_full), 64'h0);
    chk("t6_cnt",   64'(byte_count), 64'h0);
    chk("t6_rovf",  64'(overflow), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
